// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side controller.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer that absorbs the one-cycle FIFO read latency.
// Write and read pointers are single bits that wrap; head is the oldest entry.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] occ_reg;
  logic [1:0] occ_next;

  genvar gi;
  generate
    for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;

      // Capture the incoming word when the write pointer selects this entry.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_reg <= '0;
        end else if (wr_en && (int'(wr_ptr_reg) == gi)) begin
          entry_reg <= wr_data;
        end
      end
    end
  endgenerate

  assign head = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign occ  = occ_reg;

  // Occupancy moves only when exactly one of write/read happens.
  always_comb begin
    occ_next = occ_reg;
    case ({wr_en, rd_en})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
      if (rd_en) rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_next;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side burst controller: pops `len` words without underflowing
// the FIFO, buffers them in a 2-entry skid and streams them out on
// valid/ready, pulsing done after the last word is accepted.
// Optional statistics outputs are enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_words,
  output logic [CNT_W-1:0]  stat_stall
`endif
);

  rd_state_t        state_reg;
  rd_state_t        state_next;
  logic [CNT_W-1:0] remaining_reg;
  logic             inflight_reg;
  logic             done_reg;
  logic [1:0]       occ;
  logic             rd;
  logic             credit_ok;
  logic             pop;

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_reg),
    .wr_data (fifo_data),
    .rd_en   (rd),
    .occ     (occ),
    .head    (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign rd      = m_valid & m_ready;
  // A new pop is allowed only if the buffer still has room for it after
  // counting the word already on its way and the word leaving this cycle.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, rd});

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign fifo_pop = pop;

  // Next-state and pop decision.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (len != '0) ? RUN : FLUSH;
      end
      RUN: begin
        if (remaining_reg == '0) begin
          state_next = FLUSH;
        end else if (!fifo_empty && credit_ok) begin
          pop = 1'b1;
        end
      end
      FLUSH: begin
        // Leave once the buffer drains this cycle and nothing is arriving.
        if (!inflight_reg && ({1'b0, occ} == {2'b00, rd})) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, word counter, in-flight flag and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      inflight_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= pop;
      done_reg     <= (state_reg == FLUSH) && (state_next == IDLE);
      if ((state_reg == IDLE) && start) begin
        remaining_reg <= len;
      end else if (pop) begin
        remaining_reg <= remaining_reg - CNT_W'(1);
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] words_reg;
  logic [CNT_W-1:0] stall_reg;

  // Delivered-word count wraps; stall count saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_reg <= '0;
      stall_reg <= '0;
    end else begin
      if (rd) words_reg <= words_reg + CNT_W'(1);
      if ((state_reg == RUN) && (remaining_reg != '0) && fifo_empty && (stall_reg != '1)) begin
        stall_reg <= stall_reg + CNT_W'(1);
      end
    end
  end

  assign stat_words = words_reg;
  assign stat_stall = stall_reg;
`endif

endmodule
